keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad by driving one row at a time low and reading the four column lines. The row strobe is active-low one-hot, the same style as the display anode strobe, but here it is used to read the matrix rather than drive it. The block debounces presses and releases. It reports each new key once as a 4-bit code with a single-cycle valid pulse, plus a level flag while the key is held. It sits between the board keypad pins and user logic such as entry registers or a display feed.

Parameters:
SCAN_DIV, 50000, clock cycles per row period (0.5 ms at 100 MHz); must be >= 4
DEBOUNCE_CNT, 20, consecutive matching row-period samples required to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cols  input  4  keypad column lines, active-low (pulled up externally), asynchronous to clk
rows  output  4  keypad row strobe, active-low one-hot
key_code  output  4  code of last accepted key = row*4 + col
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high while the accepted key remains pressed

Behaviour:
- Input synchronisation: cols passes through a 2-FF synchronizer. All sampling uses the synchronized value cols_s.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1). It runs in every state. All sampling happens only on tick cycles.
- Row index r (2 bits); rows = ~(4'b0001 << r), registered.
- Reset values:
  - rows=4'b1110, r=0, prescaler=0
  - key_code=0, key_valid=0, key_held=0
  - synchronizer=4'b1111, state=SCAN, debounce counter=0
- Column select: if several cols_s bits are low, the lowest index wins.
- State SCAN:
  - On tick, if all cols_s are high: r <= r+1 (mod 4, so 3 wraps to 0) and rows update at the same edge.
  - On tick, if any cols_s bit is low: capture cap_row=r and cap_col=selected column, clear the debounce counter, go to DEBOUNCE. r is frozen.
- State DEBOUNCE:
  - Row is frozen.
  - On tick, if cols_s[cap_col] is low, increment the counter.
  - When the counter reaches DEBOUNCE_CNT: key_code <= {cap_row, cap_col}, key_valid=1 in the next cycle only, key_held <= 1, go to HELD.
  - On tick, if cols_s[cap_col] is high: abandon the press, go to SCAN, r <= r+1. No outputs change.
- State HELD:
  - key_held=1 and the row stays frozen.
  - On tick, if cols_s[cap_col] is high, increment the release counter; if it is low, clear the release counter.
  - When the release counter reaches DEBOUNCE_CNT: key_held <= 0, go to SCAN, r <= r+1.
  - No further key_valid pulses occur while the key is held.
  - Other keys pressed during HELD are ignored.
- key_code holds its last value until the next accepted key.
- key_valid is never high for 2 consecutive cycles.
- Latency: key_valid rises 1 cycle after the DEBOUNCE_CNT-th qualifying tick following the detection tick.
- Reset mid-operation: reset in any state returns to the reset values on the next edge. A key still held after reset is detected and reported again (new key_valid) after full debounce.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Reset, cols=4'b1111 -> all outputs at reset values; rows cycles 1110, 1101, 1011, 0111, each exactly 4 cycles, then wraps to 1110.
2. Press row2/col1 (cols[1]=0 whenever rows=1011), held steady -> rows freezes at 1011; key_valid is a single pulse 1 cycle after the 3rd qualifying tick; key_code=4'h9; key_held=1. Release -> key_held drops after 3 high ticks and rows resumes at 0111.
3. Bounce: cols[0] low for 1 tick on row0, then high -> no key_valid, key_code unchanged, scan resumes at 1101.
4. Row1 with cols=4'b0110 (col0 and col3 low), held -> key_code=4'h4.
5. Key held for 50 ticks, with one 1-tick release glitch in the middle -> exactly one key_valid pulse and key_held stays 1 throughout. Then assert reset for 1 cycle while the key is still held -> outputs clear and rows=1110; the same key is re-detected later with a fresh key_valid pulse.
6. Press row3/col3 -> key_code=4'hF; verify the detection happens on the r wrap boundary (3 -> 0 not taken).

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one active-low row at a time,
// debounces presses and releases, and reports each accepted key once as a
// 4-bit code (row*4 + col) with a one-cycle valid pulse and a held level.

module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]    cols_m;
  logic [3:0]    cols_s;
  logic [PW-1:0] pre_cnt;
  logic          tick;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    r;
  logic [1:0]    r_nx;
  logic [1:0]    cap_row;
  logic [1:0]    cap_row_nx;
  logic [1:0]    cap_col;
  logic [1:0]    cap_col_nx;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_cnt_nx;
  logic [3:0]    rows_nx;
  logic [3:0]    key_code_nx;
  logic          key_valid_nx;
  logic          key_held_nx;

  logic          any_low;
  logic [1:0]    sel_col;
  logic          cap_low;

  // Two-flop synchronizer; the column lines idle high so that is the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cols_m <= 4'b1111;
      cols_s <= 4'b1111;
    end else begin
      cols_m <= cols;
      cols_s <= cols_m;
    end
  end

  // Free-running row-period prescaler; it keeps counting in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // Pick the lowest-numbered low column and look at the captured column.
  always_comb begin
    any_low = ~&cols_s;
    sel_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols_s[i]) begin
        sel_col = 2'(i);
      end
    end
    cap_low = ~cols_s[cap_col];
  end

  // Scan / debounce / hold sequencing and the next values of every register.
  always_comb begin
    state_nx     = state;
    r_nx         = r;
    cap_row_nx   = cap_row;
    cap_col_nx   = cap_col;
    db_cnt_nx    = db_cnt;
    key_code_nx  = key_code;
    key_valid_nx = 1'b0;
    key_held_nx  = key_held;

    case (state)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cap_row_nx = r;
            cap_col_nx = sel_col;
            db_cnt_nx  = '0;
            state_nx   = DEBOUNCE;
          end else begin
            r_nx = r + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (cap_low) begin
            if (db_cnt == DB_LAST) begin
              key_code_nx  = {cap_row, cap_col};
              key_valid_nx = 1'b1;
              key_held_nx  = 1'b1;
              db_cnt_nx    = '0;
              state_nx     = HELD;
            end else begin
              db_cnt_nx = db_cnt + DW'(1);
            end
          end else begin
            db_cnt_nx = '0;
            state_nx  = SCAN;
            r_nx      = r + 2'd1;
          end
        end
      end

      HELD: begin
        if (tick) begin
          if (!cap_low) begin
            if (db_cnt == DB_LAST) begin
              key_held_nx = 1'b0;
              db_cnt_nx   = '0;
              state_nx    = SCAN;
              r_nx        = r + 2'd1;
            end else begin
              db_cnt_nx = db_cnt + DW'(1);
            end
          end else begin
            db_cnt_nx = '0;
          end
        end
      end

      default: begin
        state_nx  = SCAN;
        db_cnt_nx = '0;
      end
    endcase

    rows_nx = ~(4'b0001 << r_nx);
  end

  // State register plus the registered row strobe and key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      r         <= 2'd0;
      rows      <= 4'b1110;
      cap_row   <= 2'd0;
      cap_col   <= 2'd0;
      db_cnt    <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      r         <= r_nx;
      rows      <= rows_nx;
      cap_row   <= cap_row_nx;
      cap_col   <= cap_col_nx;
      db_cnt    <= db_cnt_nx;
      key_code  <= key_code_nx;
      key_valid <= key_valid_nx;
      key_held  <= key_held_nx;
    end
  end

endmodule
